mac_inverse_divider: RTL and testbench
======================================

Name: mac_inverse_divider

Overview:
- Sequential inverse of the pipelined multiply-add stage (DATA_OUT = A*B + C).
- Given a result word Y plus the B and C operands, recovers A by computing Q = (Y - C) / B and R = (Y - C) mod B.
- Uses a bit-serial restoring divider with valid/ready handshakes on both sides.
- Sits downstream of the MAC stage for self-check and operand recovery.

Parameters:
- WIDTH, 8: width of operands B and C and of the recovered A.
- OUT_WIDTH, 16: width of Y and of the quotient; must be >= 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- Y  input  OUT_WIDTH  MAC result to invert.
- B  input  WIDTH  divisor (multiplier operand).
- C  input  WIDTH  addend to remove.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Q  output  OUT_WIDTH  quotient (recovered A).
- R  output  WIDTH  remainder.
- div_zero  output  1  B was 0.
- underflow  output  1  Y < C.
- overrange  output  1  Q > 2^WIDTH-1, so Q is not a legal A.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - in_ready=0 while rst_n=0; in_ready=1 on the first clock after release.
  - out_valid=0, Q=0, R=0, all flags 0.
  - Internal registers cleared.
- FSM states: IDLE, SUB, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch Y, B, C and go to SUB.
- SUB (1 cycle):
  - D = Y - C, computed in OUT_WIDTH bits unsigned.
  - underflow = (Y < C, C zero-extended).
  - div_zero = (B == 0).
  - If either flag is set, go to DONE with Q=0, R=0.
  - Otherwise load dividend D, clear the partial remainder (WIDTH+1 bits), set bit counter = OUT_WIDTH-1, and go to DIV.
- DIV (OUT_WIDTH cycles, one quotient bit per cycle, MSB first):
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract B.
  - If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - After the counter reaches 0, go to DONE.
- DONE:
  - out_valid=1; Q, R and flags are stable.
  - overrange = |Q[OUT_WIDTH-1:WIDTH]|.
  - Hold all outputs until out_valid&&out_ready, then return to IDLE.
  - in_ready rises the cycle after the handshake.
- Latency, accept edge to out_valid=1:
  - Normal path: OUT_WIDTH+2 cycles (18 at defaults).
  - Flagged path: 2 cycles.
- Throughput: one request in flight. in_ready=0 in SUB, DIV and DONE.
- Backpressure: with out_ready=0 the block remains in DONE indefinitely, outputs unchanged.
- Input stability: in_valid and operands are ignored outside IDLE. Operands are sampled only on the accept edge.
- Reset mid-operation: all of the above outputs are cleared immediately (asynchronously). The partial result is discarded and no out_valid pulse is produced.
- div_zero and underflow both set: both flags report 1; Q=0, R=0.
- Width rules: all arithmetic unsigned. The remainder register is WIDTH+1 bits to absorb the trial-subtract carry. R output = low WIDTH bits.

Optional Feature:
- Macro: MAC_INVERSE_EXACT_EN.
- With the macro defined:
  - Adds output port exact (1 bit), registered, valid with out_valid.
  - exact = (R==0) && !overrange && !div_zero && !underflow.
  - exact resets to 0.
- Without the macro: no exact port and no related logic.
- All other behaviour is identical.

Test Plan:
- Y=38, B=7, C=3, out_ready=1 -> out_valid exactly 18 cycles after accept; Q=5, R=0, all flags 0; exact=1 if enabled.
- Y=40, B=7, C=3 -> Q=5, R=2, flags 0; exact=0.
- Y=100, B=0, C=4 -> out_valid after 2 cycles; div_zero=1, Q=0, R=0. Then Y=2, B=3, C=5 -> underflow=1, Q=0, R=0, latency 2.
- Y=0xFFFF, B=1, C=0 -> Q=0xFFFF, R=0, overrange=1. Then Y=0x00FF, B=1, C=0 -> Q=0x00FF, overrange=0.
- Backpressure: Y=38, B=7, C=3 with out_ready=0 for 10 cycles after out_valid -> Q/R/flags constant, in_ready=0. Assert out_ready=1 -> handshake on that edge; in_ready=1 the next cycle. A second request presented during DIV is not accepted.
- Reset mid-operation: drop rst_n during DIV, cycle 5 -> out_valid=0, Q=0, in_ready=0 immediately. After release, in_ready=1; a new request Y=38, B=7, C=3 completes normally with Q=5.

Source files
------------

// File: rtl/mac_inverse_divider.sv
// Inverse of the multiply-add stage: recovers A = (Y - C) / B with a bit-serial restoring divider.
// Optional `exact` output is enabled by defining MAC_INVERSE_EXACT_EN.
module mac_inverse_divider #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] Y,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     C,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] Q,
  output logic [WIDTH-1:0]     R,
  output logic                 div_zero,
  output logic                 underflow,
  output logic                 overrange
`ifdef MAC_INVERSE_EXACT_EN
  ,output logic                exact
`endif
);

  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t               state_r, state_s;
  logic [OUT_WIDTH-1:0] y_r, dvd_r, q_r;
  logic [WIDTH-1:0]     b_r, c_r, r_r;
  logic [WIDTH:0]       rem_r;
  logic [CW-1:0]        cnt_r;
  logic                 in_ready_r, out_valid_r, div_zero_r, underflow_r, overrange_r;
  logic [OUT_WIDTH-1:0] c_ext_s, d_s, dvd_next_s;
  logic                 underflow_s, div_zero_s, borrow_s;
  logic [WIDTH+1:0]     rem_shift_s;
  logic [WIDTH:0]       diff_s, rem_next_s;
`ifdef MAC_INVERSE_EXACT_EN
  logic                 exact_r;
`endif

  // Subtract/flag logic and one restoring-division step
  always_comb begin
    c_ext_s     = {{(OUT_WIDTH-WIDTH){1'b0}}, c_r};
    d_s         = y_r - c_ext_s;
    underflow_s = (y_r < c_ext_s);
    div_zero_s  = (b_r == {WIDTH{1'b0}});
    rem_shift_s = {rem_r, dvd_r[OUT_WIDTH-1]};
    borrow_s    = (rem_shift_s < {2'b00, b_r});
    // Without a borrow the difference is below B, so WIDTH+1 bits hold it
    diff_s      = rem_shift_s[WIDTH:0] - {1'b0, b_r};
    if (borrow_s) begin
      rem_next_s = rem_shift_s[WIDTH:0];
    end else begin
      rem_next_s = diff_s;
    end
    dvd_next_s  = {dvd_r[OUT_WIDTH-2:0], ~borrow_s};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) state_s = SUB;
        else                        state_s = IDLE;
      end
      SUB: begin
        if (underflow_s || div_zero_s) state_s = DONE;
        else                           state_s = DIV;
      end
      DIV: begin
        if (cnt_r == {CW{1'b0}}) state_s = DONE;
        else                     state_s = DIV;
      end
      DONE: begin
        if (out_valid_r && out_ready) state_s = IDLE;
        else                          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Operand capture, divider datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      dvd_r       <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      q_r         <= '0;
      r_r         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      div_zero_r  <= 1'b0;
      underflow_r <= 1'b0;
      overrange_r <= 1'b0;
`ifdef MAC_INVERSE_EXACT_EN
      exact_r     <= 1'b0;
`endif
    end else begin
      in_ready_r  <= (state_s == IDLE);
      // out_valid trails DONE entry by one cycle, giving the documented latencies
      out_valid_r <= (state_r == DONE) && !(out_valid_r && out_ready);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            y_r <= Y;
            b_r <= B;
            c_r <= C;
          end
        end
        SUB: begin
          if (underflow_s || div_zero_s) begin
            q_r         <= '0;
            r_r         <= '0;
            div_zero_r  <= div_zero_s;
            underflow_r <= underflow_s;
            overrange_r <= 1'b0;
`ifdef MAC_INVERSE_EXACT_EN
            exact_r     <= 1'b0;
`endif
          end else begin
            dvd_r <= d_s;
            rem_r <= '0;
            cnt_r <= CW'(OUT_WIDTH-1);
          end
        end
        DIV: begin
          // Quotient bits shift into the vacated low end of the dividend register
          dvd_r <= dvd_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == {CW{1'b0}}) begin
            q_r         <= dvd_next_s;
            r_r         <= rem_next_s[WIDTH-1:0];
            div_zero_r  <= 1'b0;
            underflow_r <= 1'b0;
            overrange_r <= |dvd_next_s[OUT_WIDTH-1:WIDTH];
`ifdef MAC_INVERSE_EXACT_EN
            exact_r     <= (rem_next_s[WIDTH-1:0] == {WIDTH{1'b0}}) &&
                           !(|dvd_next_s[OUT_WIDTH-1:WIDTH]);
`endif
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign Q         = q_r;
  assign R         = r_r;
  assign div_zero  = div_zero_r;
  assign underflow = underflow_r;
  assign overrange = overrange_r;
`ifdef MAC_INVERSE_EXACT_EN
  assign exact     = exact_r;
`endif

endmodule

// File: tb/tb_mac_inverse_divider.sv
// Self-checking bench for mac_inverse_divider: directed plan steps plus random requests vs. an arithmetic model.
module tb_mac_inverse_divider;
  localparam int W  = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] Y = '0;
  logic [W-1:0]  B = '0;
  logic [W-1:0]  C = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] Q;
  logic [W-1:0]  R;
  logic          div_zero, underflow, overrange;
`ifdef MAC_INVERSE_EXACT_EN
  logic          exact;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  mac_inverse_divider #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Y(Y), .B(B), .C(C),
    .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R),
    .div_zero(div_zero), .underflow(underflow), .overrange(overrange)
`ifdef MAC_INVERSE_EXACT_EN
    , .exact(exact)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [OW-1:0] y, input logic [W-1:0] b, input logic [W-1:0] c);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    Y = y; B = b; C = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    Y = OW'($urandom); B = W'($urandom); C = W'($urandom);
  endtask

  task automatic wait_result(output int l);
    l = 0;
    while (out_valid !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  // Reference: A = (Y - C) / B from plain integer arithmetic
  task automatic check_result(input logic [OW-1:0] y, input logic [W-1:0] b, input logic [W-1:0] c,
                              input int l, input string tag);
    int unsigned d, eq, er, elat;
    bit dz, uf, ov;
    dz = (b == 0);
    uf = (y < c);
    if (dz || uf) begin
      eq = 0; er = 0; elat = 2;
    end else begin
      d = int'(y) - int'(c);
      eq = d / b;
      er = d % b;
      elat = OW + 2;
    end
    ov = (eq > 255);
    chk({tag, "_latency"},   32'(l),         elat);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_q"},         32'(Q),         eq);
    chk({tag, "_r"},         32'(R),         er);
    chk({tag, "_div_zero"},  32'(div_zero),  32'(dz));
    chk({tag, "_underflow"}, 32'(underflow), 32'(uf));
    chk({tag, "_overrange"}, 32'(overrange), 32'(ov));
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
`ifdef MAC_INVERSE_EXACT_EN
    chk({tag, "_exact"}, 32'(exact), 32'((er == 0) && !ov && !dz && !uf));
`endif
  endtask

  task automatic finish_hs(input string tag);
    @(posedge clk); #1;
    chk({tag, "_hs_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_hs_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic run(input logic [OW-1:0] y, input logic [W-1:0] b, input logic [W-1:0] c, input string tag);
    int l;
    send(y, b, c);
    wait_result(l);
    check_result(y, b, c, l, tag);
    finish_hs(tag);
  endtask

  initial begin
    logic [OW-1:0] ry;
    logic [W-1:0]  rb, rc;

    #12;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q",         32'(Q),         32'd0);
    chk("rst_r",         32'(R),         32'd0);
    chk("rst_flags",     32'({div_zero, underflow, overrange}), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run(16'd38, 8'd7, 8'd3, "exact5");
    run(16'd40, 8'd7, 8'd3, "rem2");
    run(16'd100, 8'd0, 8'd4, "divzero");
    run(16'd2, 8'd3, 8'd5, "underflow");
    run(16'd2, 8'd0, 8'd5, "both_flags");
    run(16'hFFFF, 8'd1, 8'd0, "ovr_max");
    run(16'h00FF, 8'd1, 8'd0, "ovr_edge");
    run(16'h0100, 8'd1, 8'd0, "ovr_first");
    run(16'd5, 8'd5, 8'd5, "zero_dividend");
    run(16'hFFFF, 8'hFF, 8'hFF, "max_b");

    // Backpressure, with a second request held up during the busy period
    out_ready = 1'b0;
    send(16'd38, 8'd7, 8'd3);
    in_valid = 1'b1; Y = 16'd1000; B = 8'd3; C = 8'd0;
    wait_result(lat);
    check_result(16'd38, 8'd7, 8'd3, lat, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_q",     32'(Q),         32'd5);
      chk("bp_hold_r",     32'(R),         32'd0);
      chk("bp_hold_flags", 32'({div_zero, underflow, overrange}), 32'd0);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_hs("bp");

    // Asynchronous reset in the middle of the division
    send(16'd38, 8'd7, 8'd3);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q",         32'(Q),         32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_valid", 32'(out_valid), 32'd0);
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    run(16'd38, 8'd7, 8'd3, "after_rst");

    // Random requests, biased toward small divisors, zero divisors and Y < C
    for (int i = 0; i < 40; i++) begin
      ry = OW'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      if ($urandom_range(0, 3) == 0) ry = OW'($urandom_range(0, 400));
      if ($urandom_range(0, 7) == 0) rb = 8'd0;
      else if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 4));
      run(ry, rb, rc, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
